uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer downstream of the UART receiver. Detects each completed frame
//  from the receiver's RxDone level, captures RxData, and queues the byte in a
//  first-word-fall-through FIFO. The host (register block / CPU bridge) drains the
//  FIFO at its own pace. Overflow is reported with a sticky flag.
// PARAMETERS
//  DATA_W   8    byte width; matches receiver RxData
//  DEPTH    16   FIFO entries; must be a power of 2, >= 2
//  AW       4    log2(DEPTH); pointer width
// PORTS
//  Clk       in   1        system clock
//  Rst_n     in   1        async active-low reset
//  RxDone    in   1        receiver frame-done level; Tick domain, asynchronous to Clk
//  RxData    in   DATA_W   received byte; registered on Clk by the receiver
//  Flush     in   1        sync clear of FIFO contents
//  Rd_en     in   1        pop the head entry; honoured only when !Empty
//  Dout      out  DATA_W   head entry (FWFT); valid when !Empty
//  Empty     out  1        no entries
//  Full      out  1        Count == DEPTH
//  Count     out  AW+1     entries held, 0..DEPTH
//  Overflow  out  1        sticky: a frame was dropped because the FIFO was full
//  Ovf_clr   in   1        sync clear of Overflow
// BEHAVIOUR
//  Reset: pointers=0, Count=0, Empty=1, Full=0, Overflow=0, Dout=0, sync flops=0.
//   Reset can assert mid-frame; contents are discarded with no partial state.
//  Frame detect:
//   - RxDone passes through a 2-flop synchronizer (s1, s2), then an edge register (s3).
//   - wr_stb = s2 & ~s3.
//   - One write per RxDone rising edge. A level held high for many cycles gives one write.
//   - Latency: RxDone rises before Clk edge 0 -> s1@0, s2@1, write at edge 2.
//     Count and Empty update after edge 2.
//   - The byte written is RxData as sampled at the write edge. RxData is stable for
//     >= 16 Tick periods after RxDone rises.
//  Write:
//   - !Full and wr_stb: mem[wptr] <= RxData; wptr++ (wraps mod DEPTH).
//   - Full and wr_stb and !Rd_en: byte dropped, Overflow <= 1, pointers unchanged.
//   - Full and wr_stb and Rd_en: pop and push in the same cycle. Count stays DEPTH;
//     Overflow is not set.
//  Read:
//   - Dout = mem[rptr] combinationally (FWFT).
//   - Rd_en & !Empty: rptr++ (wraps) at the edge.
//   - Rd_en & Empty: ignored. No state change, no error.
//  Simultaneous events:
//   - Write and read both active and not Full: Count unchanged.
//   - Empty with wr_stb and Rd_en: write happens, read is ignored. Count goes 0->1.
//   - Flush has priority over wr_stb and Rd_en: pointers=0, Count=0; the strobed byte
//     is lost. The Overflow state is not altered by Flush.
//   - Ovf_clr in the same cycle as a new overflow: Overflow stays 1 (set wins).
//  Arithmetic:
//   - Count is a separate AW+1 register: +1 on write-only, -1 on read-only, else held.
//   - Full = (Count==DEPTH), Empty = (Count==0), both registered-derived.
//   - No wrap of Count is possible by construction.
// STRUCTURE
//  Shared package/header:
//   - UART_DATA_W = 8
//   - RX_FIFO_DEPTH = 16
//   - RX_FIFO_AW = 4 (also used by the TX-side FIFO and the register block)
//  Sub-module sync_fifo:
//   - Contains memory, pointers, Count, Full and Empty.
//   - Ports: Clk, Rst_n, Clr, Wr, Din, Rd, Dout, Count, Full, Empty.
//   - Reused for the TX path.
//  Top level: synchronizer, edge detect, overflow logic and instantiation of sync_fifo.
// TESTING
//  1. RxDone rise with RxData=8'hA5, held high 200 cycles -> exactly one write at edge 2;
//     Count=1, Dout=A5, Empty=0.
//  2. 16 frames 8'h00..8'h0F, then 17th frame 8'hFF with Rd_en=0 -> Full=1, Overflow=1,
//     Count=16. Popping 16 times gives 00..0F in order; FF is never seen.
//  3. Full FIFO, wr_stb coincident with Rd_en -> Count stays 16, Overflow stays 0, head
//     advances. The new byte appears last after draining.
//  4. Rd_en pulsed while Empty -> no pointer change, Count=0. Then frame 8'h3C with Rd_en
//     held high -> Count 0->1, then 1->0 on the next edge; Dout=3C was visible for one cycle.
//  5. Flush asserted in the wr_stb cycle with Count=5 -> Count=0, Empty=1, Overflow
//     unchanged. Ovf_clr together with a new overflow -> Overflow remains 1.
//  6. Rst_n low mid-fill (Count=7) and while RxDone=1 -> all outputs at reset values.
//     After release with RxDone still high, no spurious write occurs (s3 tracks s2).

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART sizing constants, used by the RX buffer, the TX-side FIFO and the register block.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AW    = 4;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a separate occupancy counter.
// Shared by the UART RX and TX paths.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clr,
  input  logic              Wr,
  input  logic [DATA_W-1:0] Din,
  input  logic              Rd,
  output logic [DATA_W-1:0] Dout,
  output logic [AW:0]       Count,
  output logic              Full,
  output logic              Empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              wr_ok, rd_ok;

  assign Full  = (count_q == (AW+1)'(DEPTH));
  assign Empty = (count_q == '0);
  assign Count = count_q;

  // A full FIFO still accepts a write when the same edge pops the head.
  assign rd_ok = Rd & ~Empty;
  assign wr_ok = Wr & (~Full | rd_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (Clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + AW'(1);
      if (rd_ok) rptr_d = rptr_q + AW'(1);
      if (wr_ok && !rd_ok)      count_d = count_q + (AW+1)'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_ok && !Clr) mem_q[wptr_q] <= Din;
  end

  // Forced to zero when empty so the head reads 0 out of reset.
  assign Dout = Empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: synchronises RxDone, turns each rising edge into one FIFO write,
// and flags frames dropped on a full FIFO with a sticky Overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int AW     = RX_FIFO_AW
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              RxDone,
  input  logic [DATA_W-1:0] RxData,
  input  logic              Flush,
  input  logic              Rd_en,
  output logic [DATA_W-1:0] Dout,
  output logic              Empty,
  output logic              Full,
  output logic [AW:0]       Count,
  output logic              Overflow,
  input  logic              Ovf_clr
);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] settle_q;
  logic       settled;
  logic       wr_stb;
  logic       ovf_q, ovf_d;
  logic       ovf_set;

  // The synchroniser holds reset zeros for its first edges; a level already high at
  // release must not look like a new frame, so strobes wait until s3 has caught up.
  assign settled = (settle_q == 2'd3);
  assign wr_stb  = s2_q & ~s3_q & settled;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      settle_q <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      s1_q  <= RxDone;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      ovf_q <= ovf_d;
      if (!settled) settle_q <= settle_q + 2'd1;
    end
  end

  // A set in the same cycle as Ovf_clr wins; Flush discards the strobe without flagging it.
  assign ovf_set = wr_stb & Full & ~Rd_en & ~Flush;
  assign ovf_d   = ovf_set | (ovf_q & ~Ovf_clr);

  assign Overflow = ovf_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Clr   (Flush),
    .Wr    (wr_stb),
    .Din   (RxData),
    .Rd    (Rd_en),
    .Dout  (Dout),
    .Count (Count),
    .Full  (Full),
    .Empty (Empty)
  );

endmodule
